// File: rtl/seg_capture.sv
// Monitors the multiplexed 7-segment bus and rebuilds the displayed ones/tens digits.
// Optional saturating error counter on ERR_CNT when SEG_CAPTURE_ERRCNT_EN is defined.
module seg_capture #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CA,
    input  logic [6:0] AN,
    output logic [3:0] NUM_1S,
    output logic [2:0] NUM_10S,
    output logic       VALID,
    output logic       UPDATE,
    output logic       SEG_ERR,
    output logic       STALE
`ifdef SEG_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0] ERR_CNT
`endif
);

    localparam int SW = $clog2(STABLE_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [SW-1:0] SMAX = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LATCH  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    smp_q, smp_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    num1_q, num1_d;
    logic [2:0]    num10_q, num10_d;
    logic          seen1_q, seen1_d;
    logic          seen10_q, seen10_d;
    logic          valid_q, valid_d;
    logic          upd_q, upd_d;
    logic          err_q, err_d;
    logic          stale_q, stale_d;
    logic          init_q, init_d;
    logic [7:0]    errcnt_q, errcnt_d;

    logic          chg;
    logic          ca_edge;
    logic [3:0]    dig;
    logic          dig_ok;
    logic          blank;

    always_comb begin
        dig    = 4'd0;
        dig_ok = 1'b1;
        blank  = 1'b0;
        case (smp_q[6:0])
            7'h3F:   dig = 4'd0;
            7'h06:   dig = 4'd1;
            7'h5B:   dig = 4'd2;
            7'h4F:   dig = 4'd3;
            7'h66:   dig = 4'd4;
            7'h6D:   dig = 4'd5;
            7'h7D:   dig = 4'd6;
            7'h07:   dig = 4'd7;
            7'h7F:   dig = 4'd8;
            7'h6F:   dig = 4'd9;
            7'h00:   blank = 1'b1;
            default: dig_ok = 1'b0;
        endcase
    end

    // A change is judged against the incoming sample so the stable count starts on the capture edge.
    always_comb begin
        smp_d    = {CA, AN};
        chg      = (smp_d != smp_q);
        ca_edge  = (smp_d[7] != smp_q[7]);
        scnt_d   = chg ? '0 : ((scnt_q == SMAX) ? scnt_q : scnt_q + SW'(1));
        tcnt_d   = ca_edge ? '0 : ((tcnt_q == TMAX) ? tcnt_q : tcnt_q + TW'(1));
        stale_d  = ca_edge ? 1'b0 : ((tcnt_d == TMAX) ? 1'b1 : stale_q);
        init_d   = 1'b0;
        state_d  = state_q;
        num1_d   = num1_q;
        num10_d  = num10_q;
        seen1_d  = seen1_q;
        seen10_d = seen10_q;
        upd_d    = 1'b0;
        err_d    = err_q;
        errcnt_d = errcnt_q;

        case (state_q)
            ST_WAIT: begin
                if (chg || init_q) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!chg && (scnt_q == SMAX)) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // A change arriving on the commit edge opens a fresh window immediately.
                state_d = chg ? ST_SETTLE : ST_WAIT;
                if (blank) begin
                    upd_d = 1'b0;
                end else if (!dig_ok || (smp_q[7] && (dig > 4'd5))) begin
                    err_d    = 1'b1;
                    errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
                end else if (!smp_q[7]) begin
                    num1_d  = dig;
                    seen1_d = 1'b1;
                    upd_d   = (dig != num1_q);
                end else begin
                    num10_d  = dig[2:0];
                    seen10_d = 1'b1;
                    upd_d    = (dig[2:0] != num10_q);
                end
            end
            default: state_d = ST_WAIT;
        endcase

        valid_d = seen1_d & seen10_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_WAIT;
            smp_q    <= '0;
            scnt_q   <= '0;
            tcnt_q   <= '0;
            num1_q   <= '0;
            num10_q  <= '0;
            seen1_q  <= 1'b0;
            seen10_q <= 1'b0;
            valid_q  <= 1'b0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
            init_q   <= 1'b1;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_d;
            scnt_q   <= scnt_d;
            tcnt_q   <= tcnt_d;
            num1_q   <= num1_d;
            num10_q  <= num10_d;
            seen1_q  <= seen1_d;
            seen10_q <= seen10_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
            init_q   <= init_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign NUM_1S  = num1_q;
    assign NUM_10S = num10_q;
    assign VALID   = valid_q;
    assign UPDATE  = upd_q;
    assign SEG_ERR = err_q;
    assign STALE   = stale_q;
`ifdef SEG_CAPTURE_ERRCNT_EN
    assign ERR_CNT = errcnt_q;
`else
    logic unused_errcnt;
    assign unused_errcnt = ^errcnt_q;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus random bus traffic checked every cycle
// against a run-length model of the display bus.
module tb_seg_capture;

    localparam int STABLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ca = 1'b0;
    logic [6:0] an = 7'h00;
    logic [3:0] num_1s;
    logic [2:0] num_10s;
    logic       valid;
    logic       update;
    logic       seg_err;
    logic       stale;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    always #4 clk = ~clk;

    seg_capture #(
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK    (clk),
        .RST    (rst_n),
        .CA     (ca),
        .AN     (an),
        .NUM_1S (num_1s),
        .NUM_10S(num_10s),
        .VALID  (valid),
        .UPDATE (update),
        .SEG_ERR(seg_err),
        .STALE  (stale)
`ifdef SEG_CAPTURE_ERRCNT_EN
        ,
        .ERR_CNT(err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: the bus is sampled each edge; a value seen on STABLE_CYC+1 consecutive
    // samples is committed on the following edge.
    logic [7:0] m_prev;
    int         m_run;
    int         m_ca_run;
    bit         m_pend;
    logic [7:0] m_pend_val;
    logic [3:0] e_num1;
    logic [2:0] e_num10;
    bit         e_seen1, e_seen10, e_upd, e_err;
    int         e_errcnt;

    function automatic int decode(input logic [6:0] p);
        int r;
        r = 11;
        if (p == 7'h00) r = 10;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) r = i;
        return r;
    endfunction

    task automatic model_commit(input logic [7:0] v);
        int d;
        d = decode(v[6:0]);
        if (d == 10) begin
            e_upd = 1'b0;
        end else if (d == 11 || (v[7] && d > 5)) begin
            e_err = 1'b1;
            if (e_errcnt < 255) e_errcnt++;
        end else if (!v[7]) begin
            e_upd   = (e_num1 != 4'(d));
            e_num1  = 4'(d);
            e_seen1 = 1'b1;
        end else begin
            e_upd    = (e_num10 != 3'(d));
            e_num10  = 3'(d);
            e_seen10 = 1'b1;
        end
    endtask

    task automatic model_edge();
        logic [7:0] smp;
        if (!rst_n) begin
            e_num1 = 0; e_num10 = 0; e_seen1 = 0; e_seen10 = 0;
            e_upd = 0; e_err = 0; e_errcnt = 0;
            m_pend = 0; m_pend_val = 8'h00; m_prev = 8'h00; m_run = 1; m_ca_run = 1;
        end else begin
            e_upd = 1'b0;
            if (m_pend) begin
                model_commit(m_pend_val);
                m_pend = 1'b0;
            end
            smp = {ca, an};
            if (smp == m_prev) begin
                if (m_run < 1000000) m_run++;
            end else begin
                m_run = 1;
            end
            if (smp[7] == m_prev[7]) begin
                if (m_ca_run < 1000000) m_ca_run++;
            end else begin
                m_ca_run = 1;
            end
            m_prev = smp;
            if (m_run == STABLE_CYC + 1) begin
                m_pend     = 1'b1;
                m_pend_val = smp;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("num_1s", 8'(num_1s), 8'(e_num1));
        chk("num_10s", 8'(num_10s), 8'(e_num10));
        chk("valid", 8'(valid), 8'(e_seen1 && e_seen10));
        chk("update", 8'(update), 8'(e_upd));
        chk("seg_err", 8'(seg_err), 8'(e_err));
        chk("stale", 8'(stale), 8'(m_ca_run >= TIMEOUT_CYC));
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("err_cnt", err_cnt, 8'(e_errcnt));
`endif
    endtask

    task automatic drive(input bit c, input logic [6:0] p, input int n);
        ca = c;
        an = p;
        repeat (n) tick();
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        int n;
        int r;
        logic [6:0] p;

        // Reset state
        pulse_reset(3);
        chk("rst_num_1s", 8'(num_1s), 8'h00);
        chk("rst_valid", 8'(valid), 8'h00);

        // Decode path
        drive(1'b0, 7'h5B, 40);
        chk("dec_num_1s", 8'(num_1s), 8'h02);
        drive(1'b1, 7'h4F, 40);
        chk("dec_num_10s", 8'(num_10s), 8'h03);
        chk("dec_valid", 8'(valid), 8'h01);

        // Glitch filter
        for (int i = 0; i < 12; i++) drive(1'b0, (i % 2 == 0) ? 7'h06 : 7'h5B, 5);
        drive(1'b0, 7'h06, 40);
        chk("glitch_num_1s", 8'(num_1s), 8'h01);
        chk("glitch_err", 8'(seg_err), 8'h00);

        // Illegal pattern, then a long run of legal ones digits
        drive(1'b0, 7'h49, 30);
        chk("illegal_err", 8'(seg_err), 8'h01);
        chk("illegal_num_1s", 8'(num_1s), 8'h01);
        cyc = 0;
        while (cyc < 1000) begin
            n = $urandom_range(5, 40);
            drive(1'b0, seg_tab[$urandom_range(0, 9)], n);
            cyc += n;
        end
        chk("err_sticky", 8'(seg_err), 8'h01);

        // Tens out of range, then blank
        drive(1'b1, 7'h7D, 30);
        chk("tens_range_num_10s", 8'(num_10s), 8'h03);
        drive(1'b1, 7'h00, 30);

        // Stale detection
        drive(1'b0, 7'h3F, 150);
        chk("stale_set", 8'(stale), 8'h01);
        drive(1'b1, 7'h06, 1);
        chk("stale_clr", 8'(stale), 8'h00);
        drive(1'b1, 7'h06, 30);

        // Reset in the middle of a settle window
        drive(1'b0, 7'h6F, 11);
        pulse_reset(1);
        chk("midrst_err", 8'(seg_err), 8'h00);
        drive(1'b0, 7'h6F, 30);
        chk("midrst_num_1s", 8'(num_1s), 8'h09);
        chk("midrst_valid", 8'(valid), 8'h00);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 15);
            if (r < 10) p = seg_tab[r];
            else if (r == 10) p = 7'h00;
            else if (r == 11) p = 7'($urandom);
            else p = seg_tab[$urandom_range(0, 9)];
            drive(1'($urandom_range(0, 1)), p, $urandom_range(1, 30));
        end
        drive(1'b0, 7'h3F, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
